hazard_decoder_stage: RTL and testbench
=======================================

Name: hazard_decoder_stage

Overview:
Parametrised successor to the MIPS pipeline decode stage. Contains a 2^AWIDTH-entry register file with write-back bypass, main decode, and the ID/EX pipeline register. Adds load-use hazard detection with bubble insertion, stall and flush control, and optional branch/jump resolution in ID. Sits between the fetch stage and the execute stage.

Parameters:
AWIDTH, 5, register address width; register file holds 2^AWIDTH entries; link register index is 2^AWIDTH-1.
DWIDTH, 32, data, PC and immediate-extension width.
IWIDTH, 32, instruction width (MIPS field layout, opcode [31:26]).
IMM_WIDTH, 16, raw immediate width; sign-extended to DWIDTH.
BRANCH_IN_ID, 1, 1 = BEQ/BNE resolved in ID and redirect issued; 0 = branch flag only, passed downstream.

Ports:
hds_clk in 1 clock, rising edge.
hds_rst in 1 asynchronous active-low reset.
hds_i_ce in 1 incoming instruction valid.
hds_i_instr in IWIDTH instruction.
hds_i_pc in DWIDTH PC of hds_i_instr.
hds_i_stall in 1 downstream stall; hold the pipeline register.
hds_i_flush in 1 squash the instruction being loaded.
hds_i_wb_we in 1 write-back enable.
hds_i_wb_addr in AWIDTH write-back register.
hds_i_wb_data in DWIDTH write-back data.
hds_o_ce out 1 output valid.
hds_o_opcode out 6 opcode.
hds_o_funct out 6 funct.
hds_o_rs_addr out AWIDTH rs index, used for forwarding.
hds_o_rt_addr out AWIDTH rt index.
hds_o_data_rs out DWIDTH rs value.
hds_o_data_rt out DWIDTH rt value.
hds_o_imm_ext out DWIDTH sign-extended immediate.
hds_o_wr_addr out AWIDTH destination register: rd (R-type), rt (I-type), 2^AWIDTH-1 (JAL).
hds_o_alu_src hds_o_memread hds_o_memwrite hds_o_memtoreg hds_o_reg_wr hds_o_branch hds_o_jal out 1 each: control flags.
hds_o_link_pc out DWIDTH pc+4, the JAL link value.
hds_o_redirect out 1 one-cycle fetch redirect.
hds_o_redirect_pc out DWIDTH redirect target.
hds_o_illegal out 1 unknown opcode or funct.
hds_o_hazard_stall out 1 combinational load-use stall request to fetch.

Behaviour:
- Reset (async, active-low): all outputs 0, all registers 0. Asserting reset mid-operation discards in-flight state immediately.
- Register file:
  - Write at posedge when wb_we=1 and wb_addr!=0. Register 0 always reads 0.
  - Reads are combinational, with bypass: if wb_we and wb_addr==read addr and addr!=0, wb_data is read.
- Decode:
  - R-type (opcode 0): funct 0x20/21/22/23/24/25/26 give reg_wr=1, alu_src=0.
  - ADDI 0x08: reg_wr=1, alu_src=1.
  - LW 0x23: memread=1, memtoreg=1, reg_wr=1, alu_src=1.
  - SW 0x2B: memwrite=1, alu_src=1.
  - BEQ 0x04, BNE 0x05: branch=1.
  - J 0x02.
  - JAL 0x03: jal=1, reg_wr=1.
  - Anything else: illegal=1, all other controls 0, ce passes through.
- Pipeline register update priority at each posedge: reset > flush > i_stall > hazard > load.
  - flush: load bubble (ce and all flags 0).
  - i_stall: hold every output, including redirect.
  - hazard: load bubble; the instruction is not consumed (fetch holds it via hds_o_hazard_stall).
  - load: applies only when i_ce=1; i_ce=0 loads a bubble.
- Latency: one cycle from acceptance to outputs.
- hds_o_hazard_stall=1 when all of the following hold:
  - the registered stage has ce=1, memread=1 and wr_addr!=0;
  - i_ce=1;
  - wr_addr equals incoming rs, or equals incoming rt for a type that reads rt (R-type, SW, BEQ, BNE).
  - The hazard clears after exactly one bubble.
- Redirect: registered, asserted together with the instruction's ce.
  - J/JAL target = {pc+4[DWIDTH-1:28], instr[25:0], 2'b00}.
  - BRANCH_IN_ID=1: BEQ taken if data_rs==data_rt, BNE taken if they differ (values after WB bypass). Target = pc+4+(imm_ext<<2).
  - BRANCH_IN_ID=0: redirect is never asserted for branches.
  - Redirect lasts one cycle unless held by i_stall.
- Arithmetic is modulo 2^DWIDTH; PC wrap-around is allowed.

Test Plan:
- Preload r2=5 and r3=7 via WB, then ADD 0x00430820 -> next cycle: ce=1, data_rs=5, data_rt=7, wr_addr=1, reg_wr=1, alu_src=0, illegal=0.
- WB r2=9 in the same cycle ADD is presented -> data_rs=9 (bypass). WB to r0 with data 0xFFFF -> r0 still reads 0.
- LW r1,0(r2) followed by ADD r4,r1,r3 -> hazard_stall=1 for one cycle, one bubble (ce=0), ADD issues on the following cycle. Same sequence with ADD r4,r5,r6 -> no stall.
- JAL 0x0C400000 at pc 0x100 -> jal=1, wr_addr=31, link_pc=0x104, redirect=1, redirect_pc=0x01000000.
- BEQ r2,r3,+4 at pc 0x200 with r2=r3=5 -> redirect_pc=0x214. With r3=6 -> no redirect. With BRANCH_IN_ID=0 -> branch=1, redirect=0.
- i_stall and flush asserted together -> bubble loaded. i_stall alone -> outputs hold. Reset asserted mid-stream -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/hazard_decoder_stage.sv
// MIPS-style decode stage: bypassed register file, main decode, load-use hazard
// detection and the ID/EX pipeline register with optional in-ID branch resolution.
module hazard_decoder_stage #(
  parameter int AWIDTH       = 5,
  parameter int DWIDTH       = 32,
  parameter int IWIDTH       = 32,
  parameter int IMM_WIDTH    = 16,
  parameter bit BRANCH_IN_ID = 1'b1
) (
  input  logic              hds_clk,
  input  logic              hds_rst,
  input  logic              hds_i_ce,
  input  logic [IWIDTH-1:0] hds_i_instr,
  input  logic [DWIDTH-1:0] hds_i_pc,
  input  logic              hds_i_stall,
  input  logic              hds_i_flush,
  input  logic              hds_i_wb_we,
  input  logic [AWIDTH-1:0] hds_i_wb_addr,
  input  logic [DWIDTH-1:0] hds_i_wb_data,
  output logic              hds_o_ce,
  output logic [5:0]        hds_o_opcode,
  output logic [5:0]        hds_o_funct,
  output logic [AWIDTH-1:0] hds_o_rs_addr,
  output logic [AWIDTH-1:0] hds_o_rt_addr,
  output logic [DWIDTH-1:0] hds_o_data_rs,
  output logic [DWIDTH-1:0] hds_o_data_rt,
  output logic [DWIDTH-1:0] hds_o_imm_ext,
  output logic [AWIDTH-1:0] hds_o_wr_addr,
  output logic              hds_o_alu_src,
  output logic              hds_o_memread,
  output logic              hds_o_memwrite,
  output logic              hds_o_memtoreg,
  output logic              hds_o_reg_wr,
  output logic              hds_o_branch,
  output logic              hds_o_jal,
  output logic [DWIDTH-1:0] hds_o_link_pc,
  output logic              hds_o_redirect,
  output logic [DWIDTH-1:0] hds_o_redirect_pc,
  output logic              hds_o_illegal,
  output logic              hds_o_hazard_stall
);

  localparam int NREGS = 2 ** AWIDTH;

  typedef struct packed {
    logic              ce;
    logic [5:0]        opcode;
    logic [5:0]        funct;
    logic [AWIDTH-1:0] rs_addr;
    logic [AWIDTH-1:0] rt_addr;
    logic [DWIDTH-1:0] data_rs;
    logic [DWIDTH-1:0] data_rt;
    logic [DWIDTH-1:0] imm_ext;
    logic [AWIDTH-1:0] wr_addr;
    logic              alu_src;
    logic              memread;
    logic              memwrite;
    logic              memtoreg;
    logic              reg_wr;
    logic              branch;
    logic              jal;
    logic [DWIDTH-1:0] link_pc;
    logic              redirect;
    logic [DWIDTH-1:0] redirect_pc;
    logic              illegal;
  } stage_t;

  logic [DWIDTH-1:0] r_regs [NREGS];
  stage_t            r_stage;
  stage_t            w_dec;
  stage_t            w_nxt;

  logic [5:0]        w_opcode;
  logic [5:0]        w_funct;
  logic [AWIDTH-1:0] w_rs_addr;
  logic [AWIDTH-1:0] w_rt_addr;
  logic [AWIDTH-1:0] w_rd_addr;
  logic [DWIDTH-1:0] w_data_rs;
  logic [DWIDTH-1:0] w_data_rt;
  logic [DWIDTH-1:0] w_imm_ext;
  logic [DWIDTH-1:0] w_pc4;
  logic [DWIDTH-1:0] w_br_target;
  logic [DWIDTH-1:0] w_j_target;
  logic              w_reads_rt;
  logic              w_hazard;

  assign w_opcode    = hds_i_instr[31:26];
  assign w_funct     = hds_i_instr[5:0];
  assign w_rs_addr   = hds_i_instr[21 +: AWIDTH];
  assign w_rt_addr   = hds_i_instr[16 +: AWIDTH];
  assign w_rd_addr   = hds_i_instr[11 +: AWIDTH];
  assign w_imm_ext   = {{(DWIDTH-IMM_WIDTH){hds_i_instr[IMM_WIDTH-1]}}, hds_i_instr[IMM_WIDTH-1:0]};
  assign w_pc4       = hds_i_pc + DWIDTH'(4);
  assign w_br_target = w_pc4 + {w_imm_ext[DWIDTH-3:0], 2'b00};
  assign w_j_target  = {w_pc4[DWIDTH-1:28], hds_i_instr[25:0], 2'b00};

  // Register file write port; r0 is never written and so stays zero.
  always_ff @(posedge hds_clk or negedge hds_rst) begin
    if (!hds_rst) begin
      for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
    end else if (hds_i_wb_we && (hds_i_wb_addr != '0)) begin
      r_regs[hds_i_wb_addr] <= hds_i_wb_data;
    end
  end

  // Combinational reads with same-cycle write-back bypass.
  always_comb begin
    w_data_rs = r_regs[w_rs_addr];
    w_data_rt = r_regs[w_rt_addr];
    if (w_rs_addr == '0) w_data_rs = '0;
    else if (hds_i_wb_we && (hds_i_wb_addr == w_rs_addr)) w_data_rs = hds_i_wb_data;
    else w_data_rs = r_regs[w_rs_addr];
    if (w_rt_addr == '0) w_data_rt = '0;
    else if (hds_i_wb_we && (hds_i_wb_addr == w_rt_addr)) w_data_rt = hds_i_wb_data;
    else w_data_rt = r_regs[w_rt_addr];
  end

  // Main decode of the incoming instruction into a candidate stage word.
  always_comb begin
    w_dec         = '0;
    w_reads_rt    = 1'b0;
    w_dec.ce      = 1'b1;
    w_dec.opcode  = w_opcode;
    w_dec.funct   = w_funct;
    w_dec.rs_addr = w_rs_addr;
    w_dec.rt_addr = w_rt_addr;
    w_dec.data_rs = w_data_rs;
    w_dec.data_rt = w_data_rt;
    w_dec.imm_ext = w_imm_ext;
    w_dec.link_pc = w_pc4;
    case (w_opcode)
      6'h00: begin
        w_reads_rt = 1'b1;
        case (w_funct)
          6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26: begin
            w_dec.reg_wr  = 1'b1;
            w_dec.wr_addr = w_rd_addr;
          end
          default: w_dec.illegal = 1'b1;
        endcase
      end
      6'h08: begin
        w_dec.reg_wr  = 1'b1;
        w_dec.alu_src = 1'b1;
        w_dec.wr_addr = w_rt_addr;
      end
      6'h23: begin
        w_dec.memread  = 1'b1;
        w_dec.memtoreg = 1'b1;
        w_dec.reg_wr   = 1'b1;
        w_dec.alu_src  = 1'b1;
        w_dec.wr_addr  = w_rt_addr;
      end
      6'h2B: begin
        w_reads_rt     = 1'b1;
        w_dec.memwrite = 1'b1;
        w_dec.alu_src  = 1'b1;
        w_dec.wr_addr  = w_rt_addr;
      end
      6'h04, 6'h05: begin
        w_reads_rt   = 1'b1;
        w_dec.branch = 1'b1;
        // Bit 0 of the opcode selects BNE, so taken means equality differs from it.
        if (BRANCH_IN_ID && ((w_data_rs == w_data_rt) != w_opcode[0])) begin
          w_dec.redirect    = 1'b1;
          w_dec.redirect_pc = w_br_target;
        end else begin
          w_dec.redirect    = 1'b0;
        end
      end
      6'h02: begin
        w_dec.redirect    = 1'b1;
        w_dec.redirect_pc = w_j_target;
      end
      6'h03: begin
        w_dec.jal         = 1'b1;
        w_dec.reg_wr      = 1'b1;
        w_dec.wr_addr     = '1;
        w_dec.redirect    = 1'b1;
        w_dec.redirect_pc = w_j_target;
      end
      default: w_dec.illegal = 1'b1;
    endcase
  end

  assign w_hazard = r_stage.ce && r_stage.memread && (r_stage.wr_addr != '0) && hds_i_ce &&
                    ((r_stage.wr_addr == w_rs_addr) || (w_reads_rt && (r_stage.wr_addr == w_rt_addr)));

  // Pipeline register update selection: flush, stall, hazard bubble, then load.
  always_comb begin
    w_nxt = '0;
    if (hds_i_flush)      w_nxt = '0;
    else if (hds_i_stall) w_nxt = r_stage;
    else if (w_hazard)    w_nxt = '0;
    else if (hds_i_ce)    w_nxt = w_dec;
    else                  w_nxt = '0;
  end

  // ID/EX pipeline register.
  always_ff @(posedge hds_clk or negedge hds_rst) begin
    if (!hds_rst) r_stage <= '0;
    else          r_stage <= w_nxt;
  end

  assign hds_o_ce           = r_stage.ce;
  assign hds_o_opcode       = r_stage.opcode;
  assign hds_o_funct        = r_stage.funct;
  assign hds_o_rs_addr      = r_stage.rs_addr;
  assign hds_o_rt_addr      = r_stage.rt_addr;
  assign hds_o_data_rs      = r_stage.data_rs;
  assign hds_o_data_rt      = r_stage.data_rt;
  assign hds_o_imm_ext      = r_stage.imm_ext;
  assign hds_o_wr_addr      = r_stage.wr_addr;
  assign hds_o_alu_src      = r_stage.alu_src;
  assign hds_o_memread      = r_stage.memread;
  assign hds_o_memwrite     = r_stage.memwrite;
  assign hds_o_memtoreg     = r_stage.memtoreg;
  assign hds_o_reg_wr       = r_stage.reg_wr;
  assign hds_o_branch       = r_stage.branch;
  assign hds_o_jal          = r_stage.jal;
  assign hds_o_link_pc      = r_stage.link_pc;
  assign hds_o_redirect     = r_stage.redirect;
  assign hds_o_redirect_pc  = r_stage.redirect_pc;
  assign hds_o_illegal      = r_stage.illegal;
  assign hds_o_hazard_stall = w_hazard;

endmodule

// File: tb/tb_hazard_decoder_stage.sv
// Directed bench for hazard_decoder_stage; a second instance covers BRANCH_IN_ID=0.
module tb_hazard_decoder_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_ce = 1'b0;
  logic [31:0] i_instr = 32'h0;
  logic [31:0] i_pc = 32'h0;
  logic        i_stall = 1'b0;
  logic        i_flush = 1'b0;
  logic        wb_we = 1'b0;
  logic [4:0]  wb_addr = 5'd0;
  logic [31:0] wb_data = 32'h0;

  logic        o_ce, o_alu_src, o_memread, o_memwrite, o_memtoreg, o_reg_wr;
  logic        o_branch, o_jal, o_redirect, o_illegal, o_hazard;
  logic [5:0]  o_opcode, o_funct;
  logic [4:0]  o_rs_addr, o_rt_addr, o_wr_addr;
  logic [31:0] o_data_rs, o_data_rt, o_imm_ext, o_link_pc, o_redirect_pc;

  logic        n_ce, n_alu_src, n_memread, n_memwrite, n_memtoreg, n_reg_wr;
  logic        n_branch, n_jal, n_redirect, n_illegal, n_hazard;
  logic [5:0]  n_opcode, n_funct;
  logic [4:0]  n_rs_addr, n_rt_addr, n_wr_addr;
  logic [31:0] n_data_rs, n_data_rt, n_imm_ext, n_link_pc, n_redirect_pc;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  hazard_decoder_stage dut (
    .hds_clk(clk), .hds_rst(rst_n), .hds_i_ce(i_ce), .hds_i_instr(i_instr), .hds_i_pc(i_pc),
    .hds_i_stall(i_stall), .hds_i_flush(i_flush), .hds_i_wb_we(wb_we), .hds_i_wb_addr(wb_addr),
    .hds_i_wb_data(wb_data), .hds_o_ce(o_ce), .hds_o_opcode(o_opcode), .hds_o_funct(o_funct),
    .hds_o_rs_addr(o_rs_addr), .hds_o_rt_addr(o_rt_addr), .hds_o_data_rs(o_data_rs),
    .hds_o_data_rt(o_data_rt), .hds_o_imm_ext(o_imm_ext), .hds_o_wr_addr(o_wr_addr),
    .hds_o_alu_src(o_alu_src), .hds_o_memread(o_memread), .hds_o_memwrite(o_memwrite),
    .hds_o_memtoreg(o_memtoreg), .hds_o_reg_wr(o_reg_wr), .hds_o_branch(o_branch),
    .hds_o_jal(o_jal), .hds_o_link_pc(o_link_pc), .hds_o_redirect(o_redirect),
    .hds_o_redirect_pc(o_redirect_pc), .hds_o_illegal(o_illegal), .hds_o_hazard_stall(o_hazard)
  );

  hazard_decoder_stage #(.BRANCH_IN_ID(1'b0)) dut_nb (
    .hds_clk(clk), .hds_rst(rst_n), .hds_i_ce(i_ce), .hds_i_instr(i_instr), .hds_i_pc(i_pc),
    .hds_i_stall(i_stall), .hds_i_flush(i_flush), .hds_i_wb_we(wb_we), .hds_i_wb_addr(wb_addr),
    .hds_i_wb_data(wb_data), .hds_o_ce(n_ce), .hds_o_opcode(n_opcode), .hds_o_funct(n_funct),
    .hds_o_rs_addr(n_rs_addr), .hds_o_rt_addr(n_rt_addr), .hds_o_data_rs(n_data_rs),
    .hds_o_data_rt(n_data_rt), .hds_o_imm_ext(n_imm_ext), .hds_o_wr_addr(n_wr_addr),
    .hds_o_alu_src(n_alu_src), .hds_o_memread(n_memread), .hds_o_memwrite(n_memwrite),
    .hds_o_memtoreg(n_memtoreg), .hds_o_reg_wr(n_reg_wr), .hds_o_branch(n_branch),
    .hds_o_jal(n_jal), .hds_o_link_pc(n_link_pc), .hds_o_redirect(n_redirect),
    .hds_o_redirect_pc(n_redirect_pc), .hds_o_illegal(n_illegal), .hds_o_hazard_stall(n_hazard)
  );

  task automatic chk_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic ce, input logic [31:0] instr, input logic [31:0] pc);
    i_ce    = ce;
    i_instr = instr;
    i_pc    = pc;
  endtask

  task automatic wb(input logic we, input logic [4:0] addr, input logic [31:0] data);
    wb_we   = we;
    wb_addr = addr;
    wb_data = data;
  endtask

  initial begin
    tick();
    tick();
    chk_val("rst_ce", o_ce, 0);
    chk_val("rst_reg_wr", o_reg_wr, 0);
    chk_val("rst_redirect", o_redirect, 0);
    chk_val("rst_link_pc", o_link_pc, 0);
    rst_n = 1'b1;

    // Preload r2=5, r3=7.
    wb(1'b1, 5'd2, 32'd5); tick();
    wb(1'b1, 5'd3, 32'd7); tick();
    wb(1'b0, 5'd0, 32'd0);

    // ADD r1,r2,r3
    drive(1'b1, 32'h00430820, 32'h40); tick();
    chk_val("add_ce", o_ce, 1);
    chk_val("add_rs", o_data_rs, 5);
    chk_val("add_rt", o_data_rt, 7);
    chk_val("add_wr_addr", o_wr_addr, 1);
    chk_val("add_reg_wr", o_reg_wr, 1);
    chk_val("add_alu_src", o_alu_src, 0);
    chk_val("add_illegal", o_illegal, 0);
    chk_val("add_link_pc", o_link_pc, 32'h44);
    chk_val("add_redirect", o_redirect, 0);

    // Bypass r2=9 in the same cycle.
    wb(1'b1, 5'd2, 32'd9); tick();
    chk_val("byp_rs", o_data_rs, 9);
    chk_val("byp_rt", o_data_rt, 7);

    // Write-back to r0 is ignored; ADD r1,r0,r3.
    wb(1'b1, 5'd0, 32'hFFFF);
    drive(1'b1, 32'h00030820, 32'h48); tick();
    chk_val("r0_bypass", o_data_rs, 0);
    wb(1'b0, 5'd0, 32'd0); tick();
    chk_val("r0_stored", o_data_rs, 0);

    // Illegal opcode passes ce through.
    drive(1'b1, 32'hFC000000, 32'h50); tick();
    chk_val("ill_ce", o_ce, 1);
    chk_val("ill_flag", o_illegal, 1);
    chk_val("ill_reg_wr", o_reg_wr, 0);

    // LW r1,0(r2) then dependent ADD r4,r1,r3.
    drive(1'b1, 32'h8C410000, 32'h60); tick();
    chk_val("lw_memread", o_memread, 1);
    chk_val("lw_memtoreg", o_memtoreg, 1);
    chk_val("lw_wr_addr", o_wr_addr, 1);
    chk_val("lw_alu_src", o_alu_src, 1);
    drive(1'b1, 32'h00232020, 32'h64); #1;
    chk_val("hz_stall", o_hazard, 1);
    tick();
    chk_val("hz_bubble_ce", o_ce, 0);
    chk_val("hz_cleared", o_hazard, 0);
    tick();
    chk_val("hz_add_ce", o_ce, 1);
    chk_val("hz_add_wr", o_wr_addr, 4);

    // LW then independent ADD r4,r5,r6.
    drive(1'b1, 32'h8C410000, 32'h70); tick();
    drive(1'b1, 32'h00A62020, 32'h74); #1;
    chk_val("nohz_stall", o_hazard, 0);
    tick();
    chk_val("nohz_ce", o_ce, 1);

    // JAL at 0x100.
    drive(1'b1, 32'h0C400000, 32'h100); tick();
    chk_val("jal_jal", o_jal, 1);
    chk_val("jal_wr_addr", o_wr_addr, 31);
    chk_val("jal_link", o_link_pc, 32'h104);
    chk_val("jal_redirect", o_redirect, 1);
    chk_val("jal_target", o_redirect_pc, 32'h01000000);
    drive(1'b0, 32'h0, 32'h0); tick();
    chk_val("jal_redir_once", o_redirect, 0);

    // BEQ r2,r3,+4 at 0x200 with r2=r3=5.
    wb(1'b1, 5'd2, 32'd5); tick();
    wb(1'b1, 5'd3, 32'd5); tick();
    wb(1'b0, 5'd0, 32'd0);
    drive(1'b1, 32'h10430004, 32'h200); tick();
    chk_val("beq_branch", o_branch, 1);
    chk_val("beq_redirect", o_redirect, 1);
    chk_val("beq_target", o_redirect_pc, 32'h214);
    chk_val("nb_branch", n_branch, 1);
    chk_val("nb_redirect", n_redirect, 0);
    drive(1'b0, 32'h0, 32'h0);
    wb(1'b1, 5'd3, 32'd6); tick();
    wb(1'b0, 5'd0, 32'd0);
    drive(1'b1, 32'h10430004, 32'h200); tick();
    chk_val("beq_nt_redirect", o_redirect, 0);
    drive(1'b1, 32'h14430004, 32'h200); tick();
    chk_val("bne_redirect", o_redirect, 1);
    chk_val("bne_target", o_redirect_pc, 32'h214);

    // Stall holds everything including redirect; stall+flush loads a bubble.
    drive(1'b1, 32'h0C400000, 32'h100); tick();
    i_stall = 1'b1;
    drive(1'b1, 32'h00430820, 32'h300); tick();
    chk_val("stall_redirect", o_redirect, 1);
    chk_val("stall_jal", o_jal, 1);
    chk_val("stall_link", o_link_pc, 32'h104);
    i_flush = 1'b1; tick();
    chk_val("flush_ce", o_ce, 0);
    chk_val("flush_redirect", o_redirect, 0);
    i_stall = 1'b0;
    i_flush = 1'b0;

    // Asynchronous reset mid-stream.
    drive(1'b1, 32'h00430820, 32'h400); tick();
    chk_val("pre_rst_ce", o_ce, 1);
    #2 rst_n = 1'b0;
    #1;
    chk_val("arst_ce", o_ce, 0);
    chk_val("arst_data_rs", o_data_rs, 0);
    chk_val("arst_reg_wr", o_reg_wr, 0);
    tick();
    rst_n = 1'b1;
    tick();
    chk_val("post_rst_rf", o_data_rs, 0);
    chk_val("post_rst_ce", o_ce, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
